oppm_tx_arbiter: RTL

OPPM_TX_ARBITER -- requirements
Module: oppm_tx_arbiter

---
 rtl/oppm_tx_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/oppm_tx_arbiter.sv
// oppm_tx_arbiter: shares one OPPM encoder among NUM_REQ requesters with an avail handshake and guard gap.
// Define OPPM_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default build is round-robin.
module oppm_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N_PKT   = 16,
    parameter int GAP_CT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N_PKT-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       enc_avail,
    output logic                       enc_start,
    output logic [N_PKT-1:0]           enc_data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = GAP_CT > 1 ? $clog2(GAP_CT) : 1;
`ifdef OPPM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP} state_t;

    state_t            state_q, state_d;
    logic [N_PKT-1:0]  hold_q, hold_d;
    logic [IW-1:0]     gnt_q, gnt_d, p_q, p_d, win, start;
    logic [CW-1:0]     gap_q, gap_d;
    logic              found, accept;
    int                idx;

    assign start = FIXED ? '0 : p_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Accept is combinational so the ready strobe lands in the same cycle the packet is latched.
    assign accept    = !rst && state_q == IDLE && enc_avail && found;
    assign req_ready = accept ? NUM_REQ'(1) << win : '0;
    assign enc_start = state_q == LAUNCH;
    assign enc_data  = hold_q;
    assign gnt_id    = gnt_q;
    assign busy      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        p_d     = p_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LAUNCH;
                hold_d  = req_data[int'(win)*N_PKT +: N_PKT];
                gnt_d   = win;
                p_d     = FIXED ? '0 : IW'((int'(win) + 1) % NUM_REQ);
            end
            LAUNCH:    state_d = WAIT_LOW;
            WAIT_LOW:  state_d = enc_avail ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: begin
                state_d = enc_avail ? (GAP_CT > 0 ? GAP : IDLE) : WAIT_HIGH;
                gap_d   = '0;
            end
            GAP: begin
                state_d = gap_q == CW'(GAP_CT - 1) ? IDLE : GAP;
                gap_d   = gap_q == CW'(GAP_CT - 1) ? '0 : gap_q + 1'b1;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gnt_q   <= '0;
            p_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            p_q     <= p_d;
            gap_q   <= gap_d;
        end
    end
endmodule
